ysyx_24110015_wbu: RTL and testbench

YSYX_24110015_WBU -- requirements
Module: ysyx_24110015_WBU

---
 rtl/ysyx_24110015_wbu_pkg.sv | 37 +++
 rtl/ysyx_24110015_load_ext.sv | 65 ++++++
 rtl/ysyx_24110015_wbu.sv | 142 ++++++++++++++
 tb/tb_ysyx_24110015_wbu.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24110015_wbu_pkg.sv
// Shared types and encodings for the write-back unit: load width codes,
// FSM states, CSR slot positions and the captured-entry layout.
package ysyx_24110015_wbu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Slot order inside the 128-bit CSR bus: {mcause, mepc, mtvec, mstatus}
  localparam int CSR_MSTATUS = 0;
  localparam int CSR_MTVEC   = 1;
  localparam int CSR_MEPC    = 2;
  localparam int CSR_MCAUSE  = 3;
  localparam int CSR_SLOTS   = 4;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_COMMIT = 1'b1
  } wbu_state_e;

  typedef struct packed {
    logic [31:0]  alu_out;
    logic [31:0]  pc_next;
    logic         reg_write;
    logic [4:0]   wb_addr;
    logic         zicsr;
    logic [31:0]  csr_rdata;
    logic         mem_read;
    logic [2:0]   func3;
    logic [31:0]  mem_rdata;
    logic [127:0] csr_din;
    logic [3:0]   csr_wen;
  } wbu_entry_t;

endpackage

// File: rtl/ysyx_24110015_load_ext.sv
// Combinational load data extraction: selects the byte/half/word addressed by
// the low address bits, sign/zero-extends it and flags misaligned accesses.
module ysyx_24110015_load_ext
  import ysyx_24110015_wbu_pkg::*;
(
  input  logic [2:0]  func3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o,
  output logic        misalign_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selection from the aligned memory word
  always_comb begin
    w_byte = 8'h00;
    case (offset_i)
      2'b00:   w_byte = rdata_i[7:0];
      2'b01:   w_byte = rdata_i[15:8];
      2'b10:   w_byte = rdata_i[23:16];
      2'b11:   w_byte = rdata_i[31:24];
      default: w_byte = 8'h00;
    endcase
    if (offset_i[1]) begin
      w_half = rdata_i[31:16];
    end else begin
      w_half = rdata_i[15:0];
    end
  end

  // Width/sign extension; unknown codes fall back to word behaviour
  always_comb begin
    data_o     = rdata_i;
    misalign_o = 1'b0;
    case (func3_i)
      F3_LB: begin
        data_o     = {{24{w_byte[7]}}, w_byte};
        misalign_o = 1'b0;
      end
      F3_LBU: begin
        data_o     = {24'h000000, w_byte};
        misalign_o = 1'b0;
      end
      F3_LH: begin
        data_o     = {{16{w_half[15]}}, w_half};
        misalign_o = offset_i[0];
      end
      F3_LHU: begin
        data_o     = {16'h0000, w_half};
        misalign_o = offset_i[0];
      end
      F3_LW: begin
        data_o     = rdata_i;
        misalign_o = (offset_i != 2'b00);
      end
      default: begin
        data_o     = rdata_i;
        misalign_o = (offset_i != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/ysyx_24110015_wbu.sv
// Write-back unit: captures one LSU result, presents it as a commit until the
// controller accepts it, then performs the GPR/CSR writes exactly once.
module ysyx_24110015_wbu
  import ysyx_24110015_wbu_pkg::*;
#(
  parameter int RETIRE_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         alu_out_i,
  input  logic [31:0]         pc_next_i,
  input  logic                RegWrite_i,
  input  logic [4:0]          wb_addr_i,
  input  logic                zicsr_i,
  input  logic [31:0]         csr_rdata_i,
  input  logic                MemRead_i,
  input  logic [2:0]          func3_i,
  input  logic [31:0]         mem_rdata,
  input  logic [127:0]        csr_din_i,
  input  logic [3:0]          csr_wen_i,
  input  logic                commit_ready,
  output logic                rf_wen,
  output logic [4:0]          rf_waddr,
  output logic [31:0]         rf_wdata,
  output logic [3:0]          csr_wen_o,
  output logic [127:0]        csr_din_o,
  output logic                commit,
  output logic [31:0]         pc_commit,
  output logic                load_misalign,
  output logic [RETIRE_W-1:0] retired
);

  wbu_state_e          r_state;
  wbu_state_e          w_state_nxt;
  wbu_entry_t          r_entry;
  logic [RETIRE_W-1:0] r_retired;
  logic                w_commit;
  logic                w_fire_in;
  logic                w_fire_out;
  logic [31:0]         w_load_data;
  logic                w_load_mis;
  logic                w_ld_misalign;

  assign w_commit   = (r_state == ST_COMMIT);
  assign w_fire_out = w_commit & commit_ready;
  // Accept a new entry whenever the held one leaves this cycle
  assign in_ready   = ~rst & (~w_commit | commit_ready);
  assign w_fire_in  = in_valid & in_ready;

  ysyx_24110015_load_ext u_load_ext (
    .func3_i    (r_entry.func3),
    .offset_i   (r_entry.alu_out[1:0]),
    .rdata_i    (r_entry.mem_rdata),
    .data_o     (w_load_data),
    .misalign_o (w_load_mis)
  );

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_fire_in) begin
          w_state_nxt = ST_COMMIT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_COMMIT: begin
        if (commit_ready && !in_valid) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_COMMIT;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Entry capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_entry <= '0;
    end else if (w_fire_in) begin
      r_entry.alu_out   <= alu_out_i;
      r_entry.pc_next   <= pc_next_i;
      r_entry.reg_write <= RegWrite_i;
      r_entry.wb_addr   <= wb_addr_i;
      r_entry.zicsr     <= zicsr_i;
      r_entry.csr_rdata <= csr_rdata_i;
      r_entry.mem_read  <= MemRead_i;
      r_entry.func3     <= func3_i;
      r_entry.mem_rdata <= mem_rdata;
      r_entry.csr_din   <= csr_din_i;
      r_entry.csr_wen   <= csr_wen_i;
    end
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retired <= '0;
    end else if (w_fire_out) begin
      r_retired <= r_retired + {{(RETIRE_W-1){1'b0}}, 1'b1};
    end
  end

  assign w_ld_misalign = r_entry.mem_read & w_load_mis;

  // Write-data source selection
  always_comb begin
    rf_wdata = r_entry.alu_out;
    if (r_entry.zicsr) begin
      rf_wdata = r_entry.csr_rdata;
    end else if (r_entry.mem_read) begin
      rf_wdata = w_load_data;
    end else begin
      rf_wdata = r_entry.alu_out;
    end
  end

  assign rf_wen        = w_fire_out & r_entry.reg_write & (r_entry.wb_addr != 5'd0) & ~w_ld_misalign;
  assign rf_waddr      = r_entry.wb_addr;
  assign csr_wen_o     = w_fire_out ? r_entry.csr_wen : 4'b0000;
  assign csr_din_o     = r_entry.csr_din;
  assign commit        = w_commit;
  assign pc_commit     = r_entry.pc_next;
  assign load_misalign = w_commit & w_ld_misalign;
  assign retired       = r_retired;

endmodule

// File: tb/tb_ysyx_24110015_wbu.sv
// Scenario bench for the write-back unit: expected commits are queued when an
// entry is issued and popped when the commit is observed.
module tb_ysyx_24110015_wbu;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  alu_out_i;
  logic [31:0]  pc_next_i;
  logic         RegWrite_i;
  logic [4:0]   wb_addr_i;
  logic         zicsr_i;
  logic [31:0]  csr_rdata_i;
  logic         MemRead_i;
  logic [2:0]   func3_i;
  logic [31:0]  mem_rdata;
  logic [127:0] csr_din_i;
  logic [3:0]   csr_wen_i;
  logic         commit_ready;
  logic         rf_wen;
  logic [4:0]   rf_waddr;
  logic [31:0]  rf_wdata;
  logic [3:0]   csr_wen_o;
  logic [127:0] csr_din_o;
  logic         commit;
  logic [31:0]  pc_commit;
  logic         load_misalign;
  logic [63:0]  retired;

  typedef struct packed {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  cwen;
    logic        mis;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        e;
  exp_t        obs;
  int          checks = 0;
  int          errors = 0;
  int          wr_cnt = 0;
  int          cw_cnt = 0;
  logic [63:0] ret_base;
  int          wr_base;

  always #5 clk = ~clk;

  ysyx_24110015_wbu #(.RETIRE_W(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_out_i(alu_out_i), .pc_next_i(pc_next_i), .RegWrite_i(RegWrite_i),
    .wb_addr_i(wb_addr_i), .zicsr_i(zicsr_i), .csr_rdata_i(csr_rdata_i),
    .MemRead_i(MemRead_i), .func3_i(func3_i), .mem_rdata(mem_rdata),
    .csr_din_i(csr_din_i), .csr_wen_i(csr_wen_i), .commit_ready(commit_ready),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .csr_wen_o(csr_wen_o), .csr_din_o(csr_din_o), .commit(commit),
    .pc_commit(pc_commit), .load_misalign(load_misalign), .retired(retired)
  );

  always @(posedge clk) begin
    if (rf_wen === 1'b1) wr_cnt <= wr_cnt + 1;
    if (csr_wen_o !== 4'b0000) cw_cnt <= cw_cnt + 1;
  end

  task automatic idle_inputs();
    in_valid = 1'b0; alu_out_i = 32'h0; pc_next_i = 32'h0; RegWrite_i = 1'b0;
    wb_addr_i = 5'd0; zicsr_i = 1'b0; csr_rdata_i = 32'h0; MemRead_i = 1'b0;
    func3_i = 3'b000; mem_rdata = 32'h0; csr_din_i = 128'h0; csr_wen_i = 4'b0000;
  endtask

  task automatic issue(input logic [31:0] alu, input logic [31:0] pc, input logic rw,
                       input logic [4:0] rd, input logic zc, input logic [31:0] crd,
                       input logic mr, input logic [2:0] f3, input logic [31:0] md,
                       input logic [127:0] cdin, input logic [3:0] cwen, input exp_t ex);
    in_valid = 1'b1; alu_out_i = alu; pc_next_i = pc; RegWrite_i = rw; wb_addr_i = rd;
    zicsr_i = zc; csr_rdata_i = crd; MemRead_i = mr; func3_i = f3; mem_rdata = md;
    csr_din_i = cdin; csr_wen_i = cwen;
    sb_q.push_back(ex);
  endtask

  task automatic pop_exp(output exp_t ex);
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard empty at %0t", $time);
      ex = '0;
    end else begin
      ex = sb_q.pop_front();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; commit_ready = 1'b0; idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({commit, rf_wen, csr_wen_o, load_misalign, rf_wdata, pc_commit} !== 39'h0 || retired !== 64'h0) begin
      errors++;
      $display("FAIL reset_outputs got commit=%b wen=%b cwen=%b mis=%b wdata=%h pc=%h ret=%0d want all zero",
               commit, rf_wen, csr_wen_o, load_misalign, rf_wdata, pc_commit, retired);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_lb();
    @(negedge clk);
    commit_ready = 1'b1;
    ret_base = retired; wr_base = wr_cnt;
    issue(32'h0000_1003, 32'h8000_0004, 1'b1, 5'd10, 1'b0, 32'h0, 1'b1, 3'b000,
          32'h80FF_1234, 128'h0, 4'b0000, '{1'b1, 5'd10, 32'hFFFF_FF80, 4'b0000, 1'b0, 32'h8000_0004});
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    #1;
    pop_exp(e);
    obs = {rf_wen, rf_waddr, rf_wdata, csr_wen_o, load_misalign, pc_commit};
    checks++;
    if (commit !== 1'b1 || obs !== e) begin
      errors++;
      $display("FAIL lb_commit got commit=%b obs=%h want commit=1 obs=%h", commit, obs, e);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (commit !== 1'b0 || rf_wen !== 1'b0 || retired !== ret_base + 64'd1 || wr_cnt != wr_base + 1) begin
      errors++;
      $display("FAIL lb_after got commit=%b wen=%b ret=%0d writes=%0d want 0 0 %0d %0d",
               commit, rf_wen, retired, wr_cnt - wr_base, ret_base + 64'd1, 1);
    end
  endtask

  task automatic test_misalign();
    @(negedge clk);
    commit_ready = 1'b1;
    ret_base = retired; wr_base = wr_cnt;
    issue(32'h0000_2001, 32'h8000_0010, 1'b1, 5'd7, 1'b0, 32'h0, 1'b1, 3'b101,
          32'hABCD_8765, 128'h0, 4'b0000, '{1'b0, 5'd7, 32'h0000_8765, 4'b0000, 1'b1, 32'h8000_0010});
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    #1;
    pop_exp(e);
    obs = {rf_wen, rf_waddr, rf_wdata, csr_wen_o, load_misalign, pc_commit};
    checks++;
    if (commit !== 1'b1 || obs !== e) begin
      errors++;
      $display("FAIL lhu_misalign got commit=%b obs=%h want commit=1 obs=%h", commit, obs, e);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (retired !== ret_base + 64'd1 || wr_cnt != wr_base) begin
      errors++;
      $display("FAIL lhu_retire got ret=%0d writes=%0d want %0d 0", retired, wr_cnt - wr_base, ret_base + 64'd1);
    end
  endtask

  task automatic test_x0_lh();
    @(negedge clk);
    commit_ready = 1'b1;
    wr_base = wr_cnt;
    issue(32'h0000_2002, 32'h8000_0020, 1'b1, 5'd0, 1'b0, 32'h0, 1'b1, 3'b001,
          32'h8001_0000, 128'h0, 4'b0000, '{1'b0, 5'd0, 32'hFFFF_8001, 4'b0000, 1'b0, 32'h8000_0020});
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    #1;
    pop_exp(e);
    obs = {rf_wen, rf_waddr, rf_wdata, csr_wen_o, load_misalign, pc_commit};
    checks++;
    if (commit !== 1'b1 || obs !== e) begin
      errors++;
      $display("FAIL lh_x0 got commit=%b obs=%h want commit=1 obs=%h", commit, obs, e);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (wr_cnt != wr_base) begin
      errors++;
      $display("FAIL lh_x0_nowrite got writes=%0d want 0", wr_cnt - wr_base);
    end
  endtask

  task automatic test_stall();
    @(negedge clk);
    commit_ready = 1'b0;
    ret_base = retired; wr_base = wr_cnt;
    issue(32'h1234_5678, 32'h8000_0030, 1'b1, 5'd3, 1'b0, 32'h0, 1'b0, 3'b000,
          32'h0, 128'h0, 4'b0000, '{1'b1, 5'd3, 32'h1234_5678, 4'b0000, 1'b0, 32'h8000_0030});
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (commit !== 1'b1 || in_ready !== 1'b0 || rf_wen !== 1'b0 || rf_wdata !== 32'h1234_5678 ||
          pc_commit !== 32'h8000_0030 || retired !== ret_base) begin
        errors++;
        $display("FAIL stall_hold[%0d] got commit=%b rdy=%b wen=%b wdata=%h pc=%h ret=%0d want 1 0 0 12345678 80000030 %0d",
                 i, commit, in_ready, rf_wen, rf_wdata, pc_commit, retired, ret_base);
      end
      @(negedge clk);
    end
    commit_ready = 1'b1;
    #1;
    pop_exp(e);
    obs = {rf_wen, rf_waddr, rf_wdata, csr_wen_o, load_misalign, pc_commit};
    checks++;
    if (obs !== e || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release got obs=%h rdy=%b want obs=%h rdy=1", obs, in_ready, e);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (commit !== 1'b0 || retired !== ret_base + 64'd1 || wr_cnt != wr_base + 1) begin
      errors++;
      $display("FAIL stall_single_write got commit=%b ret=%0d writes=%0d want 0 %0d 1",
               commit, retired, wr_cnt - wr_base, ret_base + 64'd1);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    commit_ready = 1'b1;
    ret_base = retired; wr_base = wr_cnt;
    issue(32'h0000_0011, 32'h8000_0040, 1'b1, 5'd1, 1'b0, 32'h0, 1'b0, 3'b000,
          32'h0, 128'h0, 4'b0000, '{1'b1, 5'd1, 32'h0000_0011, 4'b0000, 1'b0, 32'h8000_0040});
    @(posedge clk);
    @(negedge clk);
    issue(32'h0000_0022, 32'h8000_0044, 1'b1, 5'd2, 1'b0, 32'h0, 1'b0, 3'b000,
          32'h0, 128'h0, 4'b0000, '{1'b1, 5'd2, 32'h0000_0022, 4'b0000, 1'b0, 32'h8000_0044});
    #1;
    pop_exp(e);
    obs = {rf_wen, rf_waddr, rf_wdata, csr_wen_o, load_misalign, pc_commit};
    checks++;
    if (commit !== 1'b1 || in_ready !== 1'b1 || obs !== e) begin
      errors++;
      $display("FAIL b2b_first got commit=%b rdy=%b obs=%h want 1 1 obs=%h", commit, in_ready, obs, e);
    end
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    #1;
    pop_exp(e);
    obs = {rf_wen, rf_waddr, rf_wdata, csr_wen_o, load_misalign, pc_commit};
    checks++;
    if (commit !== 1'b1 || obs !== e) begin
      errors++;
      $display("FAIL b2b_second got commit=%b obs=%h want commit=1 obs=%h", commit, obs, e);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (commit !== 1'b0 || retired !== ret_base + 64'd2 || wr_cnt != wr_base + 2) begin
      errors++;
      $display("FAIL b2b_retire got commit=%b ret=%0d writes=%0d want 0 %0d 2",
               commit, retired, wr_cnt - wr_base, ret_base + 64'd2);
    end
  endtask

  task automatic test_csr();
    @(negedge clk);
    commit_ready = 1'b1;
    wr_base = cw_cnt;
    issue(32'h0000_0300, 32'h8000_0050, 1'b1, 5'd5, 1'b1, 32'hDEAD_BEEF, 1'b0, 3'b000, 32'h0,
          {32'h0000_000B, 32'h8000_004C, 32'h8000_1000, 32'h0000_1800}, 4'b0100,
          '{1'b1, 5'd5, 32'hDEAD_BEEF, 4'b0100, 1'b0, 32'h8000_0050});
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    #1;
    pop_exp(e);
    obs = {rf_wen, rf_waddr, rf_wdata, csr_wen_o, load_misalign, pc_commit};
    checks++;
    if (commit !== 1'b1 || obs !== e ||
        csr_din_o !== {32'h0000_000B, 32'h8000_004C, 32'h8000_1000, 32'h0000_1800}) begin
      errors++;
      $display("FAIL csr_commit got commit=%b obs=%h din=%h want commit=1 obs=%h", commit, obs, csr_din_o, e);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (csr_wen_o !== 4'b0000 || cw_cnt != wr_base + 1) begin
      errors++;
      $display("FAIL csr_once got cwen=%b csr_writes=%0d want 0000 1", csr_wen_o, cw_cnt - wr_base);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    commit_ready = 1'b0;
    wr_base = wr_cnt;
    issue(32'h0000_4000, 32'h8000_0060, 1'b1, 5'd4, 1'b0, 32'h0, 1'b1, 3'b010,
          32'hCAFE_F00D, 128'h0, 4'b1111, '{1'b0, 5'd0, 32'h0, 4'b0000, 1'b0, 32'h0});
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    checks++;
    if (commit !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pending got commit=%b want 1", commit);
    end
    rst = 1'b1;
    commit_ready = 1'b1;
    #1;
    pop_exp(e);
    obs = {rf_wen, rf_waddr, rf_wdata, csr_wen_o, load_misalign, pc_commit};
    checks++;
    if (commit !== 1'b0 || obs !== e || retired !== 64'h0) begin
      errors++;
      $display("FAIL rstmid_outputs got commit=%b obs=%h ret=%0d want 0 obs=%h ret=0", commit, obs, retired, e);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || commit !== 1'b0 || retired !== 64'h0 || wr_cnt != wr_base) begin
      errors++;
      $display("FAIL rstmid_release got rdy=%b commit=%b ret=%0d writes=%0d want 1 0 0 0",
               in_ready, commit, retired, wr_cnt - wr_base);
    end
  endtask

  initial begin
    test_reset();
    test_lb();
    test_misalign();
    test_x0_lh();
    test_stall();
    test_back_to_back();
    test_csr();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
